// File: rtl/vga_pkg.sv
// Shared timing definitions for the video raster generator: mode records,
// standard mode constants and helpers for totals and segment decode.
package vga_pkg;

  // One complete raster mode: horizontal and vertical segment lengths.
  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } vga_timing_t;

  // Position of a counter within a line (or a frame, for the vertical axis).
  typedef enum logic [1:0] {
    SEG_ACTIVE,
    SEG_FP,
    SEG_SYNC,
    SEG_BP
  } seg_t;

  localparam vga_timing_t VGA_640x480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33
  };

  localparam vga_timing_t VGA_800x600_60 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23
  };

  // Full period of one axis in counts.
  function automatic int unsigned total(input int unsigned active,
                                        input int unsigned fp,
                                        input int unsigned sync,
                                        input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Classify a counter value; segments run active, front porch, sync, back porch.
  function automatic seg_t segment(input int unsigned pos,
                                   input int unsigned active,
                                   input int unsigned fp,
                                   input int unsigned sync);
    seg_t s;
    if (pos < active)                  s = SEG_ACTIVE;
    else if (pos < active + fp)        s = SEG_FP;
    else if (pos < active + fp + sync) s = SEG_SYNC;
    else                               s = SEG_BP;
    return s;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Strobe-enabled shift register used to align sync/DE with a downstream
// pixel pipeline. DEPTH=0 is a plain wire.
module vga_sync_delay #(
  parameter int unsigned        WIDTH   = 3,
  parameter int unsigned        DEPTH   = 0,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stb,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused;
    assign unused = &{1'b0, clk, rst_n, stb, flush};
    assign q      = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per strobe; flush returns every stage to the idle value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else if (flush) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else if (stb) begin
        stage[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator. The h/v counters hold the pixel that
// the next strobe will present; every output is registered on that strobe.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_640x480_60.h_active,
  parameter int unsigned H_FP     = VGA_640x480_60.h_fp,
  parameter int unsigned H_SYNC   = VGA_640x480_60.h_sync,
  parameter int unsigned H_BP     = VGA_640x480_60.h_bp,
  parameter int unsigned V_ACTIVE = VGA_640x480_60.v_active,
  parameter int unsigned V_FP     = VGA_640x480_60.v_fp,
  parameter int unsigned V_SYNC   = VGA_640x480_60.v_sync,
  parameter int unsigned V_BP     = VGA_640x480_60.v_bp,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned PIPE_DLY = 0,
  localparam int unsigned XW = $clog2(total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  localparam int unsigned YW = $clog2(total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_pix_stb,
  input  logic          i_en,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_de,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_line_start,
  output logic          o_frame_start,
  output logic          o_animate
);

  localparam int unsigned H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [XW-1:0] H_LAST  = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST  = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] H_ALAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] V_ALAST = YW'(V_ACTIVE - 1);

  // Idle levels for {hs, vs, de}, shared by reset, disable and the delay line.
  localparam logic [2:0] SYNC_IDLE = {~HS_POL, ~VS_POL, 1'b0};

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h
    $error("vga_timing_gen: horizontal segments must all be >= 1");
  end
  if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v
    $error("vga_timing_gen: vertical segments must all be >= 1");
  end
  if (PIPE_DLY > 7) begin : g_bad_dly
    $error("vga_timing_gen: PIPE_DLY must be 0..7");
  end

  logic [XW-1:0] h;
  logic [YW-1:0] v;
  seg_t          h_seg;
  seg_t          v_seg;
  logic          h_wrap;
  logic          v_wrap;

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          hs_q;
  logic          vs_q;
  logic          de_q;
  logic          line_start_q;
  logic          frame_start_q;
  logic          animate_q;
  logic [2:0]    sync_dly;

  // Segment decode of the pixel about to be presented.
  always_comb begin
    h_seg  = segment(32'(h), H_ACTIVE, H_FP, H_SYNC);
    v_seg  = segment(32'(v), V_ACTIVE, V_FP, V_SYNC);
    h_wrap = (h == H_LAST);
    v_wrap = (v == V_LAST);
  end

  // Raster counters: advance per strobe, park at the origin while disabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h <= '0;
      v <= '0;
    end else if (!i_en) begin
      h <= '0;
      v <= '0;
    end else if (i_pix_stb) begin
      if (h_wrap) begin
        h <= '0;
        v <= v_wrap ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  // Output registers: coordinates and sync/DE load on a strobe, pulses last one clk.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q           <= '0;
      y_q           <= '0;
      {hs_q, vs_q, de_q} <= SYNC_IDLE;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      animate_q     <= 1'b0;
    end else if (!i_en) begin
      x_q           <= '0;
      y_q           <= '0;
      {hs_q, vs_q, de_q} <= SYNC_IDLE;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      animate_q     <= 1'b0;
    end else begin
      line_start_q  <= i_pix_stb && (h == '0);
      frame_start_q <= i_pix_stb && (h == '0) && (v == '0);
      animate_q     <= i_pix_stb && (h == H_ALAST) && (v == V_ALAST);
      if (i_pix_stb) begin
        x_q  <= h;
        y_q  <= v;
        hs_q <= (h_seg == SEG_SYNC) ? HS_POL : ~HS_POL;
        vs_q <= (v_seg == SEG_SYNC) ? VS_POL : ~VS_POL;
        de_q <= (h_seg == SEG_ACTIVE) && (v_seg == SEG_ACTIVE);
      end
    end
  end

  // The delay stages shift on the same strobe that reloads hs_q/vs_q/de_q,
  // so stage N holds the decode of the pixel N strobes before o_x.
  vga_sync_delay #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .stb   (i_pix_stb),
    .flush (~i_en),
    .d     ({hs_q, vs_q, de_q}),
    .q     (sync_dly)
  );

  assign o_hs          = sync_dly[2];
  assign o_vs          = sync_dly[1];
  assign o_de          = sync_dly[0];
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;
  assign o_animate     = animate_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance, a small positive-polarity
// mode, and the same small mode with a 3-strobe sync/DE delay.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stb = 1'b0;
  logic en = 1'b0;

  always #5 clk = ~clk;

  logic       d_hs, d_vs, d_de, d_ls, d_fs, d_an;
  logic [9:0] d_x;
  logic [9:0] d_y;
  logic       s_hs, s_vs, s_de, s_ls, s_fs, s_an;
  logic [3:0] s_x;
  logic [2:0] s_y;
  logic       p_hs, p_vs, p_de, p_ls, p_fs, p_an;
  logic [3:0] p_x;
  logic [2:0] p_y;

  vga_timing_gen dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb), .i_en(en),
    .o_hs(d_hs), .o_vs(d_vs), .o_de(d_de), .o_x(d_x), .o_y(d_y),
    .o_line_start(d_ls), .o_frame_start(d_fs), .o_animate(d_an)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb), .i_en(en),
    .o_hs(s_hs), .o_vs(s_vs), .o_de(s_de), .o_x(s_x), .o_y(s_y),
    .o_line_start(s_ls), .o_frame_start(s_fs), .o_animate(s_an)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .PIPE_DLY(3)
  ) dut_p (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb), .i_en(en),
    .o_hs(p_hs), .o_vs(p_vs), .o_de(p_de), .o_x(p_x), .o_y(p_y),
    .o_line_start(p_ls), .o_frame_start(p_fs), .o_animate(p_an)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // One clock with the given strobe level; returns 1 time unit after the edge.
  task automatic tick(input logic s);
    stb = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    stb   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    en    = 1'b1;
    tick(1'b0);
  endtask

  // Small-mode vector: strobe index, expected outputs of dut_s, and the
  // delayed de/hs of dut_p (its o_x must equal the undelayed x).
  typedef struct {
    int unsigned s;
    logic [3:0]  x;
    logic [2:0]  y;
    logic        hs, vs, de, ls, fs, an;
    logic        pde, phs;
  } vec_t;

  vec_t tbl[15];

  int ls_gap, fs_gap, hs_x0, hs_len, de_cnt, ls_wmax, vs_len;

  task automatic measure(input int per, input int ncyc);
    int ls1, ls2, fs1, fs2, ls_run;
    logic s;
    ls1 = -1; ls2 = -1; fs1 = -1; fs2 = -1; ls_run = 0;
    hs_x0 = -1; hs_len = 0; de_cnt = 0; ls_wmax = 0; vs_len = 0;
    for (int i = 0; i < ncyc; i++) begin
      s = ((i % per) == 0);
      tick(s);
      if (d_ls) begin
        if (ls1 < 0) ls1 = i;
        else if (ls2 < 0) ls2 = i;
      end
      ls_run = d_ls ? ls_run + 1 : 0;
      if (ls_run > ls_wmax) ls_wmax = ls_run;
      if (ls1 >= 0 && ls2 < 0) begin
        if (!d_hs) begin
          hs_len++;
          if (hs_x0 < 0) hs_x0 = 32'(d_x);
        end
        if (s && d_de) de_cnt++;
      end
      if (s_fs) begin
        if (fs1 < 0) fs1 = i;
        else if (fs2 < 0) fs2 = i;
      end
      if (fs1 >= 0 && fs2 < 0 && s_vs) vs_len++;
    end
    ls_gap = ls2 - ls1;
    fs_gap = fs2 - fs1;
  endtask

  initial begin
    int unsigned sdone;
    int n;
    int bad;

    //          s   x  y  hs vs de ls fs an pde phs
    tbl[0]  = '{ 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1};
    tbl[1]  = '{ 7, 7, 0, 0, 0, 1, 0, 0, 0, 1, 1};
    tbl[2]  = '{ 8, 8, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[3]  = '{ 9, 9, 0, 1, 0, 0, 0, 0, 0, 1, 1};
    tbl[4]  = '{10,10, 0, 1, 0, 0, 0, 0, 0, 1, 1};
    tbl[5]  = '{11,11, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[6]  = '{12, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[7]  = '{43, 7, 3, 0, 0, 1, 0, 0, 1, 1, 1};
    tbl[8]  = '{44, 8, 3, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[9]  = '{48, 0, 4, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[10] = '{60, 0, 5, 0, 1, 0, 1, 0, 0, 0, 0};
    tbl[11] = '{69, 9, 5, 1, 1, 0, 0, 0, 0, 0, 1};
    tbl[12] = '{72, 0, 6, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[13] = '{83,11, 6, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[14] = '{84, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0};

    // Reset state of all three instances.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_default", 32'({d_x, d_y, d_hs, d_vs, d_de, d_ls, d_fs, d_an}),
          32'({10'd0, 10'd0, 6'b110000}));
    check("rst_small", 32'({s_x, s_y, s_hs, s_vs, s_de, s_ls, s_fs, s_an}),
          32'({4'd0, 3'd0, 6'b000000}));
    check("rst_pipe", 32'({p_x, p_y, p_hs, p_vs, p_de, p_ls, p_fs, p_an}),
          32'({4'd0, 3'd0, 6'b110000}));

    // Small mode, strobe every clock, walk the vector table.
    do_reset();
    sdone = 0;
    for (int k = 0; k < 15; k++) begin
      while (sdone <= tbl[k].s) begin
        tick(1'b1);
        sdone++;
      end
      check($sformatf("vec%0d_s%0d", k, tbl[k].s),
            32'({s_x, s_y, s_hs, s_vs, s_de, s_ls, s_fs, s_an, p_x, p_de, p_hs}),
            32'({tbl[k].x, tbl[k].y, tbl[k].hs, tbl[k].vs, tbl[k].de,
                 tbl[k].ls, tbl[k].fs, tbl[k].an, tbl[k].x, tbl[k].pde, tbl[k].phs}));
    end

    // Delay line start-up: de appears three strobes after (0,0), x undelayed.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b1);
      check($sformatf("pipe_start_s%0d", i), 32'({p_x, p_de}),
            32'({4'(i), (i >= 3) ? 1'b1 : 1'b0}));
    end

    // Default and small modes, strobe every clock and every fourth clock.
    for (int per = 1; per <= 4; per += 3) begin
      do_reset();
      measure(per, (per == 1) ? 900 : 3300);
      check($sformatf("line_period_p%0d", per), ls_gap, 800 * per);
      check($sformatf("hs_start_x_p%0d", per), hs_x0, 656);
      check($sformatf("hs_width_p%0d", per), hs_len, 96 * per);
      check($sformatf("de_strobes_p%0d", per), de_cnt, 640);
      check($sformatf("ls_width_p%0d", per), ls_wmax, 1);
      check($sformatf("small_frame_period_p%0d", per), fs_gap, 84 * per);
      check($sformatf("small_vs_width_p%0d", per), vs_len, 12 * per);
    end

    // Asynchronous reset mid-line on the default instance.
    do_reset();
    n = 0;
    while (!(d_x == 10'd300 && d_y == 10'd1) && n < 2000) begin
      tick(1'b1);
      n++;
    end
    check("t5_reach", 32'(d_x == 10'd300 && d_y == 10'd1), 1);
    stb = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_idle", 32'({d_x, d_y, d_hs, d_vs, d_de, d_ls, d_fs, d_an}),
          32'({10'd0, 10'd0, 6'b110000}));
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick(1'b0);
    tick(1'b0);
    check("t5_hold_no_pulse", 32'({d_x, d_de, d_ls, d_fs}), 32'({10'd0, 3'b000}));
    tick(1'b1);
    check("t5_first_strobe", 32'({d_x, d_y, d_de, d_ls, d_fs}),
          32'({10'd0, 10'd0, 3'b111}));

    // Drop enable on the small instance at y=2 for 50 clocks.
    n = 0;
    while (!(s_y == 3'd2 && s_x == 4'd3) && n < 200) begin
      tick(1'b1);
      n++;
    end
    check("t6_reach", 32'(s_y == 3'd2 && s_x == 4'd3), 1);
    en  = 1'b0;
    bad = 0;
    repeat (50) begin
      tick(1'b1);
      if ({s_x, s_y, s_hs, s_vs, s_de, s_ls, s_fs, s_an} != '0) bad++;
      if ({p_hs, p_de, p_ls, p_fs} != 4'b1000) bad++;
    end
    check("t6_disabled_idle", bad, 0);
    en = 1'b1;
    tick(1'b1);
    check("t6_reenable_small", 32'({s_x, s_y, s_de, s_ls, s_fs, s_hs, s_vs}),
          32'({4'd0, 3'd0, 5'b11100}));
    check("t6_reenable_pipe", 32'({p_x, p_de, p_hs}), 32'({4'd0, 2'b01}));
    repeat (3) tick(1'b1);
    check("t6_pipe_refill", 32'({p_x, p_de}), 32'({4'd3, 1'b1}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
